// File: rtl/operand_fetch_stage_if.sv
// Fetch-to-execute bundle for the operand fetch stage: input handshake, register bank view,
// writeback bypass and the decoded operand output.
interface operand_fetch_stage_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RW = $clog2(NREGS);

    logic                         in_valid;
    logic                         in_ready;
    logic [31:0]                  instr;
    logic                         flush;
    logic [NREGS-1:0][XLEN-1:0]   register_bank;
    logic                         wb_en;
    logic [RW-1:0]                wb_rd;
    logic [XLEN-1:0]              wb_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [XLEN-1:0]              op1;
    logic [XLEN-1:0]              op2;
    logic [XLEN-1:0]              op3;
    logic [RW-1:0]                rd;
    logic [31:0]                  out_instr;
    logic                         illegal;

    modport master (
        output in_valid, instr, flush, register_bank, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, op1, op2, op3, rd, out_instr, illegal
    );

    modport slave (
        input  in_valid, instr, flush, register_bank, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, op1, op2, op3, rd, out_instr, illegal
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: registers one instruction, presents operands read from the bank with bypass.
// One cycle latency; in_ready = !out_valid || out_ready, so a stalled execute holds the word and blocks fetch.
module operand_fetch_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_fetch_stage_if.slave io
);
    localparam int RW = $clog2(NREGS);

    typedef enum logic {EMPTY, FULL} state_e;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SI, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

    state_e          state_q, state_d;
    fmt_e            fmt_q, fmt_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [RW-1:0]   rs1_q, rs2_q, rd_q;
    logic [31:0]     instr_q;
    logic            accept;
    logic [XLEN-1:0] r1, r2;

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic signed [11:0] imm_i, imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;
    logic [5:0]         shamt;
    logic               bad_rs1, bad_rs2, bad_rd;

    assign opc   = io.instr[6:0];
    assign f3    = io.instr[14:12];
    assign imm_i = io.instr[31:20];
    assign imm_s = {io.instr[31:25], io.instr[11:7]};
    assign imm_b = {io.instr[31], io.instr[7], io.instr[30:25], io.instr[11:8], 1'b0};
    assign imm_u = {io.instr[31:12], 12'b0};
    assign imm_j = {io.instr[31], io.instr[19:12], io.instr[20], io.instr[30:21], 1'b0};
    assign shamt = (XLEN == 64) ? io.instr[25:20] : {1'b0, io.instr[24:20]};

    // Only reachable when the bank is smaller than the 32-entry architectural space
    assign bad_rs1 = {1'b0, io.instr[19:15]} >= 6'(NREGS);
    assign bad_rs2 = {1'b0, io.instr[24:20]} >= 6'(NREGS);
    assign bad_rd  = {1'b0, io.instr[11:7]}  >= 6'(NREGS);

    always_comb begin
        fmt_d = FMT_NONE;
        ill_d = 1'b0;
        imm_d = '0;
        case (opc)
            7'b0110011:             fmt_d = FMT_R;
            7'b0010011:             fmt_d = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SI : FMT_I;
            7'b0000011, 7'b1100111: fmt_d = FMT_I;
            7'b0100011:             fmt_d = FMT_S;
            7'b1100011:             fmt_d = FMT_B;
            7'b0110111, 7'b0010111: fmt_d = FMT_U;
            7'b1101111:             fmt_d = FMT_J;
            7'b1110011:             ill_d = (io.instr != 32'h0010_0073);
            default:                ill_d = 1'b1;
        endcase
        case (fmt_d)
            FMT_R:         ill_d = bad_rs1 | bad_rs2 | bad_rd;
            FMT_I, FMT_SI: ill_d = bad_rs1 | bad_rd;
            FMT_S, FMT_B:  ill_d = bad_rs1 | bad_rs2;
            FMT_U, FMT_J:  ill_d = bad_rd;
            default:       ;
        endcase
        case (fmt_d)
            FMT_I:   imm_d = XLEN'(imm_i);
            FMT_SI:  imm_d = XLEN'(shamt);
            FMT_S:   imm_d = XLEN'(imm_s);
            FMT_B:   imm_d = XLEN'(imm_b);
            FMT_U:   imm_d = XLEN'(imm_u);
            FMT_J:   imm_d = XLEN'(imm_j);
            default: imm_d = '0;
        endcase
        if (ill_d) begin
            fmt_d = FMT_NONE;
            imm_d = '0;
        end
    end

    assign io.in_ready  = (state_q == EMPTY) || io.out_ready;
    assign io.out_valid = (state_q == FULL);
    assign accept       = io.in_valid && io.in_ready && !io.flush;

    always_comb begin
        state_d = state_q;
        if (io.flush)
            state_d = EMPTY;
        else if (accept)
            state_d = FULL;
        else if (state_q == FULL && io.out_ready)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmt_q   <= FMT_NONE;
            ill_q   <= 1'b0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            instr_q <= '0;
        end else if (accept) begin
            fmt_q   <= fmt_d;
            ill_q   <= ill_d;
            imm_q   <= imm_d;
            rs1_q   <= io.instr[15 +: RW];
            rs2_q   <= io.instr[20 +: RW];
            rd_q    <= io.instr[7 +: RW];
            instr_q <= io.instr;
        end
    end

    // Bypass covers the cycle in which the bank has not yet absorbed the writeback
    always_comb begin
        r1 = io.register_bank[rs1_q];
        r2 = io.register_bank[rs2_q];
        if (BYPASS && io.wb_en && io.wb_rd == rs1_q) r1 = io.wb_data;
        if (BYPASS && io.wb_en && io.wb_rd == rs2_q) r2 = io.wb_data;
        if (rs1_q == '0) r1 = '0;
        if (rs2_q == '0) r2 = '0;
    end

    always_comb begin
        io.op1     = '0;
        io.op2     = '0;
        io.op3     = '0;
        io.illegal = 1'b0;
        if (state_q == FULL) begin
            io.illegal = ill_q;
            case (fmt_q)
                FMT_R: begin
                    io.op1 = r1;
                    io.op2 = r2;
                end
                FMT_I, FMT_SI: begin
                    io.op1 = r1;
                    io.op2 = imm_q;
                end
                FMT_S, FMT_B: begin
                    io.op1 = r1;
                    io.op2 = r2;
                    io.op3 = imm_q;
                end
                FMT_U, FMT_J: io.op1 = imm_q;
                default: ;
            endcase
        end
    end

    assign io.rd        = rd_q;
    assign io.out_instr = instr_q;
endmodule
